// File: rtl/mem_copy_master.sv
// Memory-to-memory copy master.
// Copies `len` words from a source region to a destination region, one word
// at a time, through a single shared memory port. Each word is a READ access
// followed by a WRITE access; every access waits for the responder's
// M_DataRdy acknowledge and is abandoned if the acknowledge does not arrive
// within TIMEOUT wait cycles.
module mem_copy_master #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              start_port,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              done_port,
    output logic              err,

    output logic              Mout_oe_ram,
    output logic              Mout_we_ram,
    output logic [ADDR_W-1:0] Mout_addr_ram,
    output logic [DATA_W-1:0] Mout_Wdata_ram,
    output logic [7:0]        Mout_data_ram_size,
    input  logic [DATA_W-1:0] M_Rdata_ram,
    input  logic              M_DataRdy
);

    // The wait counter only has to reach TIMEOUT; keep it at least one bit wide.
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(TIMEOUT);
    localparam logic [7:0]        ACCESS_SIZE = 8'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q,   src_d;
    logic [ADDR_W-1:0]   dst_q,   dst_d;
    logic [ADDR_W-1:0]   len_q,   len_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                err_q,   err_d;

    logic [ADDR_W-1:0]   countNext;
    logic                waitExpired;

    assign countNext   = count_q + ADDR_W'(1);
    assign waitExpired = (wait_q == WAIT_LIMIT);

    // State and datapath registers; reset returns everything to an idle, error-free copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: sequence READ/WRITE per word, count waits, abort on timeout.
    // An acknowledge in the same cycle the wait count hits the limit still wins.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        wait_d  = wait_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start_port) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    count_d = '0;
                    wait_d  = '0;
                    err_d   = 1'b0;
                    state_d = (len == '0) ? DONE : READ;
                end
            end

            READ: begin
                if (M_DataRdy) begin
                    data_d  = M_Rdata_ram;
                    wait_d  = '0;
                    state_d = WRITE;
                end else if (waitExpired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end

            WRITE: begin
                if (M_DataRdy) begin
                    count_d = countNext;
                    wait_d  = '0;
                    state_d = (countNext == len_q) ? DONE : READ;
                end else if (waitExpired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port drive: requests are decoded straight from the state so the
    // bus is quiet (all zero) whenever no access is in flight.
    always_comb begin
        Mout_oe_ram        = 1'b0;
        Mout_we_ram        = 1'b0;
        Mout_addr_ram      = '0;
        Mout_Wdata_ram     = '0;
        Mout_data_ram_size = '0;

        case (state_q)
            READ: begin
                Mout_oe_ram        = 1'b1;
                Mout_addr_ram      = src_q + count_q;
                Mout_data_ram_size = ACCESS_SIZE;
            end
            WRITE: begin
                Mout_we_ram        = 1'b1;
                Mout_addr_ram      = dst_q + count_q;
                Mout_Wdata_ram     = data_q;
                Mout_data_ram_size = ACCESS_SIZE;
            end
            default: begin
                Mout_oe_ram = 1'b0;
            end
        endcase
    end

    assign done_port = (state_q == DONE);
    assign err       = err_q;

endmodule

// File: doc/mem_copy_master.md
MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 Parameter ADDR_W, default 7, sets the width of the master memory port byte address.
REQ-002 Parameter DATA_W, default 8, sets the width of the data bus; one transfer moves one DATA_W word.
REQ-003 Parameter TIMEOUT, default 255, is the maximum number of wait cycles allowed per access before the copy aborts.
REQ-004 clock  in  1  Single clock; all state is updated on its rising edge.
REQ-005 reset  in  1  Asynchronous, active-high reset.
REQ-006 start_port  in  1  Single-cycle copy request, sampled in IDLE only.
REQ-007 src_addr  in  ADDR_W  First source address, captured on an accepted start.
REQ-008 dst_addr  in  ADDR_W  First destination address, captured on an accepted start.
REQ-009 len  in  ADDR_W  Number of words to copy, captured on an accepted start.
REQ-010 done_port  out  1  One-cycle pulse when a copy completes or aborts.
REQ-011 err  out  1  Timeout flag, valid while done_port=1 and held until the next accepted start.
REQ-012 Mout_oe_ram  out  1  Read request.
REQ-013 Mout_we_ram  out  1  Write request.
REQ-014 Mout_addr_ram  out  ADDR_W  Access address.
REQ-015 Mout_Wdata_ram  out  DATA_W  Write data.
REQ-016 Mout_data_ram_size  out  8  Access size in bits.
REQ-017 M_Rdata_ram  in  DATA_W  Read data, valid in the cycle M_DataRdy=1.
REQ-018 M_DataRdy  in  1  Responder acknowledge, for both reads and writes.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-020 IDLE + start_port=1, len!=0 SHALL capture src/dst/len, clear err, clear count, and enter READ on the next cycle.
REQ-021 IDLE + start_port=1, len=0 SHALL go directly to DONE with err=0.
REQ-022 A start_port asserted outside IDLE SHALL be ignored.
REQ-023 READ SHALL drive Mout_oe_ram=1, Mout_addr_ram=src+count, Mout_data_ram_size=DATA_W, and hold them stable until M_DataRdy=1.
REQ-024 READ + M_DataRdy=1 SHALL latch M_Rdata_ram into the data register and enter WRITE.
REQ-025 WRITE SHALL drive Mout_we_ram=1, Mout_addr_ram=dst+count, Mout_Wdata_ram=the latched data, Mout_data_ram_size=DATA_W, held stable until M_DataRdy=1.
REQ-026 WRITE + M_DataRdy=1 SHALL increment count; the FSM SHALL enter DONE if count+1==len, otherwise READ.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W, so src/dst wrap past the all-ones address to 0.
REQ-028 Mout_oe_ram and Mout_we_ram SHALL never be 1 in the same cycle.
REQ-029 Outside READ/WRITE, oe, we, address, wdata and size SHALL all be 0.
REQ-030 M_DataRdy SHALL be ignored in IDLE and DONE.
REQ-031 A wait counter SHALL clear on every READ/WRITE entry and increment each cycle that M_DataRdy=0.
REQ-032 When the wait counter reaches TIMEOUT with M_DataRdy still 0, the FSM SHALL set err=1, drop the request the next cycle, and enter DONE.
REQ-033 DONE SHALL assert done_port=1 for exactly one cycle and then return to IDLE.
REQ-034 With a responder acknowledging reads after Dr cycles and writes after Dw cycles (counting the request cycle), done_port SHALL rise 1+len*(Dr+Dw) cycles after the start cycle.
REQ-035 M_DataRdy arriving in the same cycle the wait counter hits TIMEOUT SHALL count as success (no abort).

Reset
REQ-036 Asserting reset at any time, including mid-access, SHALL immediately force IDLE.
REQ-037 Reset SHALL clear done_port, err, oe, we, address, wdata, size, count, the wait counter and the data register to 0.
REQ-038 After reset deassertion, the first start SHALL be accepted on the first rising edge.

Verification
REQ-039 Responder Dr=2/Dw=1 with mem[0..3]=11,22,33,44; start src=0, dst=16, len=4 -> mem[16..19]=11,22,33,44, done_port 13 cycles after start, err=0.
REQ-040 start with len=0 -> done_port 1 cycle after start, oe/we never asserted.
REQ-041 src=126, dst=0, len=3 (ADDR_W=7) -> reads 126,127,0; writes 0,1,2.
REQ-042 Responder never acknowledges, TIMEOUT=4 -> oe held 5 cycles, then done_port=1 with err=1; next start clears err.
REQ-043 Reset asserted during a WRITE -> oe/we/done_port are 0 immediately; a subsequent copy of len=2 completes correctly.
REQ-044 start_port pulsed during READ -> ignored; the captured src/dst/len are unchanged and exactly one done_port pulse occurs.
